param_cpu_core: RTL
===================

# param_cpu_core

Parametrised multi-cycle processor core that succeeds the fixed 4-bit, 4-register CPU. Data width, register count and instruction-memory depth are parameters. The core adds an on-chip program memory with a load mode, an autonomous run mode, carry/borrow flags, and a conditional branch. It is the top compute block of the lab CPU: switches and buttons drive the load/execute inputs, and `leds` and `done` drive the board indicators.

## Interface
Parameters:
- `WIDTH`, default 4: datapath and register width in bits (≥2).
- `NREGS`, default 4: number of general registers (power of 2, ≥2). `RA = clog2(NREGS)`.
- `IMEM_DEPTH`, default 16: program words (power of 2, ≤ 2^WIDTH). `PA = clog2(IMEM_DEPTH)`.
- `INSTR_W`, derived as `3 + RA + WIDTH`. Fields are `op[INSTR_W-1 -: 3]`, `rd[RA+WIDTH-1 -: RA]`, `imm[WIDTH-1:0]`. The `rs` field is `imm[RA-1:0]`.

Ports:
- `clk`, in, 1: single clock. All logic is rising-edge.
- `reset`, in, 1: **asynchronous, active-high** reset.
- `switch_mode`, in, 1: 0 = load mode, 1 = run mode.
- `load_en`, in, 1: load mode only. Writes `instruction` to `imem[load_addr]`.
- `load_addr`, in, PA: program write address.
- `instruction`, in, INSTR_W: program word to be written.
- `execute`, in, 1: run mode only. Starts a program at PC=0.
- `leds`, out, WIDTH: the last value written to any register.
- `carry`, out, 1: carry flag from the last ADD, or borrow flag from the last SUB.
- `busy`, out, 1: high in the FETCH, EXEC and WB states.
- `done`, out, 1: high in the HALTED state.

## Operation
- Opcodes:
  - 0 LOAD: `rd ← imm`
  - 1 MOV: `rd ← R[rs]`
  - 2 ADD: `rd ← rd + R[rs]`
  - 3 SUB: `rd ← rd − R[rs]`
  - 4 AND: `rd ← rd & R[rs]`
  - 5 XOR: `rd ← rd ^ R[rs]`
  - 6 BRZ: if `R[rd] == 0` then `PC ← imm[PA-1:0]`
  - 7 HALT
- Arithmetic wraps mod 2^WIDTH.
  - ADD: `carry` = bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB: `carry` = 1 when `rd < R[rs]` (unsigned borrow).
  - All other opcodes leave `carry` unchanged.
- FSM states:
  - IDLE:
    - `execute && switch_mode` → FETCH, with PC ← 0.
    - `load_en && !switch_mode` writes imem, state unchanged.
  - FETCH: `ir ← imem[pc]` → EXEC.
  - EXEC: ALU result into `res`, flag into `c_nxt` → WB.
  - WB:
    - Writes `R[rd] ← res` and `leds ← res` for opcodes 0–5.
    - Updates `carry` for ADD/SUB.
    - Sets PC to the BRZ target or to `pc+1`. PC wraps `IMEM_DEPTH-1 → 0`.
    - HALT → HALTED. Anything else → FETCH.
  - HALTED: `execute && switch_mode` → FETCH, PC ← 0. `switch_mode == 0` → IDLE.
- `execute` and `load_en` are ignored while `busy`. Imem is never written during a run.
- There is no halt-less termination: a program without HALT loops forever.
- Registers and `leds` are **not** cleared when a new run starts.
- Reset values: state IDLE, PC 0, all registers 0, `leds` 0, `carry` 0, `busy` 0, `done` 0.
- Imem contents are not reset. Imem reset value is don't-care; bench loads before running.
- Reset asserted mid-run aborts immediately to the reset values.

## Timing
- `execute` is sampled at edge k. FETCH is active in cycle k+1.
- Every instruction takes exactly 3 cycles (F, E, W).
- A program of n instructions ending in HALT raises `done` 3n cycles after edge k.
- Register writes become visible to the next instruction's EXEC; there are no hazards.
- The `load_en` write takes effect at the sampling edge. Reading the same address later sees the new word.
- Outputs are registered, with no combinational path from any input to any output.
- `busy` and `done` are never both high.

## Structure
- Package `cpu_pkg`:
  - opcode localparams `OP_LOAD` … `OP_HALT`
  - state enum `IDLE`/`FETCH`/`EXEC`/`WB`/`HALTED`
  - field-extraction helpers
- Sub-module `param_alu`:
  - inputs `a`, `b`, `op`
  - outputs `y`, `c`
  - combinational, WIDTH-parametrised
- Register file and imem stay inline.

## Test plan
All scenarios use `WIDTH=4`, `NREGS=4`, `IMEM_DEPTH=16`.
- **Reset:** assert `reset` mid-EXEC → `busy` = 0, `leds` = 0, `carry` = 0 and IDLE in the same cycle, asynchronously.
- **Arithmetic:** load LOAD R0,5; LOAD R1,12; ADD R0,R1; HALT, then pulse `execute` → `done` rises 12 cycles later, `leds` = 1, `carry` = 1.
- **Subtraction:** LOAD R2,3; LOAD R3,7; SUB R2,R3; HALT → `leds` = 12, `carry` = 1. Then a second run with R2=7, R3=3 → `leds` = 4, `carry` = 0.
- **Branch loop:** LOAD R0,3; LOAD R1,1; SUB R0,R1; BRZ R0,5; BRZ R2,2 (R2=0); HALT at address 5 → halts with R0=0, `leds` = 0.
- **PC wrap:** HALT at address 0, NOP-like LOADs at 1–15, then run starting via a BRZ to 1 → PC wraps 15→0 and halts.
- **Ignored inputs:** assert `load_en` and `execute` while `busy` → imem is unchanged and the run is not restarted.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcodes, controller states and instruction-field helpers for param_cpu_core.
package cpu_pkg;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_MOV  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_BRZ  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  // Helpers take a zero-extended instruction so one definition serves every width.
  localparam int FIELD_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    WB,
    HALTED
  } state_t;

  function automatic logic [2:0] instr_op(input logic [FIELD_W-1:0] instr,
                                          input int instr_w);
    return instr[instr_w-1 -: 3];
  endfunction

  function automatic logic [FIELD_W-1:0] instr_rd(input logic [FIELD_W-1:0] instr,
                                                  input int ra, input int width);
    return (instr >> width) & ((FIELD_W'(1) << ra) - FIELD_W'(1));
  endfunction

  function automatic logic [FIELD_W-1:0] instr_imm(input logic [FIELD_W-1:0] instr,
                                                   input int width);
    return instr & ((FIELD_W'(1) << width) - FIELD_W'(1));
  endfunction

  function automatic logic writes_reg(input logic [2:0] op);
    return op <= OP_XOR;
  endfunction

  function automatic logic writes_carry(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/param_cpu_core_alu.sv
// Combinational ALU: a is R[rd], b is R[rs] (or the immediate for LOAD); c is carry/borrow.
module param_alu
  import cpu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             c
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  // The extra top bit of the difference is set exactly when a < b (unsigned borrow).
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    y = '0;
    c = 1'b0;
    case (op)
      OP_LOAD: y = b;
      OP_MOV:  y = b;
      OP_ADD: begin
        y = w_sum[WIDTH-1:0];
        c = w_sum[WIDTH];
      end
      OP_SUB: begin
        y = w_diff[WIDTH-1:0];
        c = w_diff[WIDTH];
      end
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      default: ;
    endcase
  end

endmodule

// File: rtl/param_cpu_core.sv
// Multi-cycle core: program memory with load mode, FETCH/EXEC/WB run loop, carry flag and BRZ.
module param_cpu_core
  import cpu_pkg::*;
#(
  parameter  int WIDTH      = 4,
  parameter  int NREGS      = 4,
  parameter  int IMEM_DEPTH = 16,
  localparam int RA         = $clog2(NREGS),
  localparam int PA         = $clog2(IMEM_DEPTH),
  localparam int INSTR_W    = 3 + RA + WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               switch_mode,
  input  logic               load_en,
  input  logic [PA-1:0]      load_addr,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               execute,
  output logic [WIDTH-1:0]   leds,
  output logic               carry,
  output logic               busy,
  output logic               done
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PA-1:0]      r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic [WIDTH-1:0]   r_res;
  logic               r_c_nxt;
  logic               r_brz_take;
  logic [WIDTH-1:0]   r_regs [NREGS];
  logic [INSTR_W-1:0] r_imem [IMEM_DEPTH];
  logic [WIDTH-1:0]   r_leds;
  logic               r_carry;
  logic               r_busy;
  logic               r_done;

  logic [2:0]         w_op;
  logic [RA-1:0]      w_rd;
  logic [RA-1:0]      w_rs;
  logic [WIDTH-1:0]   w_imm;
  logic [WIDTH-1:0]   w_alu_b;
  logic [WIDTH-1:0]   w_alu_y;
  logic               w_alu_c;
  logic               w_start;
  logic               w_load;

  assign w_op  = instr_op(FIELD_W'(r_ir), INSTR_W);
  assign w_rd  = RA'(instr_rd(FIELD_W'(r_ir), RA, WIDTH));
  assign w_imm = WIDTH'(instr_imm(FIELD_W'(r_ir), WIDTH));
  assign w_rs  = w_imm[RA-1:0];

  assign w_start = ((r_state == IDLE) || (r_state == HALTED)) && execute && switch_mode;
  assign w_load  = (r_state == IDLE) && load_en && !switch_mode;

  assign w_alu_b = (w_op == OP_LOAD) ? w_imm : r_regs[w_rs];

  param_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a  (r_regs[w_rd]),
    .b  (w_alu_b),
    .op (w_op),
    .y  (w_alu_y),
    .c  (w_alu_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = FETCH;
      FETCH:   w_state_nxt = EXEC;
      EXEC:    w_state_nxt = WB;
      WB:      w_state_nxt = (w_op == OP_HALT) ? HALTED : FETCH;
      HALTED: begin
        if (w_start)           w_state_nxt = FETCH;
        else if (!switch_mode) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Architectural state: cleared by reset, kept across runs otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= '0;
      r_leds  <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_busy <= (w_state_nxt == FETCH) || (w_state_nxt == EXEC) || (w_state_nxt == WB);
      r_done <= (w_state_nxt == HALTED);
      if (w_start) begin
        r_pc <= '0;
      end else if (r_state == WB) begin
        if (writes_reg(w_op)) begin
          r_regs[w_rd] <= r_res;
          r_leds       <= r_res;
        end
        if (writes_carry(w_op)) r_carry <= r_c_nxt;
        if ((w_op == OP_BRZ) && r_brz_take) r_pc <= PA'(w_imm);
        else                                r_pc <= r_pc + PA'(1);
      end
    end
  end

  // Per-instruction pipeline holding registers, only meaningful inside a run.
  always_ff @(posedge clk) begin
    if (r_state == FETCH) r_ir <= r_imem[r_pc];
    if (r_state == EXEC) begin
      r_res      <= w_alu_y;
      r_c_nxt    <= w_alu_c;
      r_brz_take <= (r_regs[w_rd] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_load) r_imem[load_addr] <= instruction;
  end

  assign leds  = r_leds;
  assign carry = r_carry;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
